// File: rtl/tube_pkg.sv
// Tube parasite-side shared definitions.
// Channel indices, status bit layout and control flag positions.
package tube_pkg;

  localparam int R1 = 0;
  localparam int R2 = 1;
  localparam int R3 = 2;
  localparam int R4 = 3;

  localparam int ST_AVAIL    = 7;
  localparam int ST_NOT_FULL = 6;

  localparam int CTRL_Q = 3;
  localparam int CTRL_I = 2;
  localparam int CTRL_J = 1;
  localparam int CTRL_M = 0;

  typedef enum logic [1:0] {
    NMI_IDLE,
    NMI_ASSERT,
    NMI_HOLD
  } nmi_state_t;

  function automatic logic [7:0] status_byte(
    input logic       avail,
    input logic       not_full,
    input logic [3:0] ctrl
  );
    logic [7:0] s;
    s              = 8'h03;
    s[ST_AVAIL]    = avail;
    s[ST_NOT_FULL] = not_full;
    s[5:2]         = ctrl;
    return s;
  endfunction

endpackage

// File: rtl/tube_p_regif_if.sv
// Parasite CPU bus as seen by the Tube register interface.
// The CPU side is the master; the register file is the slave.
interface tube_p_regif_if;
  logic       p_cs_b;
  logic [2:0] p_addr;
  logic       p_rdnw;
  logic [7:0] p_dout;

  modport master (
    output p_cs_b,
    output p_addr,
    output p_rdnw,
    input  p_dout
  );

  modport slave (
    input  p_cs_b,
    input  p_addr,
    input  p_rdnw,
    output p_dout
  );
endinterface

// File: rtl/tube_nmi_gen.sv
// Parasite NMI generator.
// Guarantees a minimum low time, then follows the request.
module tube_nmi_gen
  import tube_pkg::*;
#(
  parameter int NMI_MIN_LOW = 2
) (
  input  logic p_phi2,
  input  logic p_rst,
  input  logic i_req,
  output logic o_nmi_b
);

  localparam logic [3:0] CNT_LOAD = 4'(NMI_MIN_LOW - 1);

  nmi_state_t r_state;
  nmi_state_t w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;

  // state and hold counter registers
  always_ff @(posedge p_phi2) begin
    if (p_rst) begin
      r_state <= NMI_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // next state, counter and active-low NMI output
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_nmi_b     = 1'b1;
    unique case (r_state)
      NMI_IDLE: begin
        if (i_req) begin
          w_state_nxt = NMI_ASSERT;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      NMI_ASSERT: begin
        o_nmi_b = 1'b0;
        if (r_cnt == 4'd0)
          w_state_nxt = i_req ? NMI_HOLD : NMI_IDLE;
        else
          w_cnt_nxt = r_cnt - 4'd1;
      end
      NMI_HOLD: begin
        o_nmi_b = 1'b0;
        if (!i_req)
          w_state_nxt = NMI_IDLE;
      end
      default: w_state_nxt = NMI_IDLE;
    endcase
  end

endmodule

// File: rtl/tube_p_regif.sv
// Tube parasite-side register interface.
// Decodes CPU accesses, strobes the buffers, drives PIRQ/PNMI.
module tube_p_regif
  import tube_pkg::*;
#(
  parameter int NMI_MIN_LOW = 2
) (
  input  logic                 p_phi2,
  input  logic                 p_rst,
  tube_p_regif_if.slave        bus,
  input  logic [31:0]          hp_data,
  input  logic [3:0]           hp_avail,
  input  logic [3:0]           ph_not_full,
  input  logic [3:0]           ctrl_q_i_j_m,
  output logic [3:0]           hp_select,
  output logic [3:0]           ph_select,
  output logic                 p_irq_b,
  output logic                 p_nmi_b
);

  logic       r_cs_b_q;
  logic       r_armed;
  logic [7:0] r_dout;
  logic       r_irq_b;

  logic [1:0] w_ch;
  logic       w_start;
  logic       w_dat_rd;
  logic       w_dat_wr;
  logic       w_st_rd;
  logic [3:0] w_onehot;
  logic [7:0] w_rd_byte;
  logic       w_irq;
  logic       w_nmi_req;

  assign w_ch     = bus.p_addr[2:1];
  // armed blocks a strobe for an access already underway at reset
  assign w_start  = !p_rst & r_armed & r_cs_b_q & !bus.p_cs_b;
  assign w_dat_rd = w_start & bus.p_addr[0] & bus.p_rdnw;
  assign w_dat_wr = w_start & bus.p_addr[0] & !bus.p_rdnw;
  assign w_st_rd  = w_start & !bus.p_addr[0] & bus.p_rdnw;
  assign w_onehot = 4'b0001 << w_ch;

  assign hp_select = w_dat_rd ? w_onehot : 4'b0000;
  assign ph_select = w_dat_wr ? w_onehot : 4'b0000;

  // read data mux: data byte or status byte
  always_comb begin
    w_rd_byte = status_byte(hp_avail[w_ch],
                            ph_not_full[w_ch],
                            ctrl_q_i_j_m);
    if (bus.p_addr[0])
      w_rd_byte = hp_data[{w_ch, 3'b000} +: 8];
  end

  // chip-select edge tracking
  always_ff @(posedge p_phi2) begin
    if (p_rst) begin
      r_cs_b_q <= 1'b1;
      r_armed  <= 1'b0;
    end else begin
      r_cs_b_q <= bus.p_cs_b;
      r_armed  <= r_armed | bus.p_cs_b;
    end
  end

  // capture read data at the start of a read
  always_ff @(posedge p_phi2) begin
    if (p_rst)
      r_dout <= 8'h00;
    else if (w_dat_rd | w_st_rd)
      r_dout <= w_rd_byte;
  end

  assign bus.p_dout = r_dout;

  assign w_irq =
    (ctrl_q_i_j_m[CTRL_I] & hp_avail[R1]) |
    (ctrl_q_i_j_m[CTRL_J] & hp_avail[R4]);

  // registered active-low parasite IRQ
  always_ff @(posedge p_phi2) begin
    if (p_rst)
      r_irq_b <= 1'b1;
    else
      r_irq_b <= !w_irq;
  end

  assign p_irq_b = r_irq_b;

  assign w_nmi_req = ctrl_q_i_j_m[CTRL_M] & hp_avail[R3];

  tube_nmi_gen #(
    .NMI_MIN_LOW (NMI_MIN_LOW)
  ) u_nmi (
    .p_phi2  (p_phi2),
    .p_rst   (p_rst),
    .i_req   (w_nmi_req),
    .o_nmi_b (p_nmi_b)
  );

endmodule

// File: tb/tb_tube_p_regif.sv
// Bench for tube_p_regif.
// Expectations are queued per cycle; a monitor checks each negedge.
module tb_tube_p_regif;

  localparam int SIG_HP   = 0;
  localparam int SIG_PH   = 1;
  localparam int SIG_DOUT = 2;
  localparam int SIG_IRQ  = 3;
  localparam int SIG_NMI  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] hp_data = 32'h4433A511;
  logic [3:0]  hp_avail = 4'h0;
  logic [3:0]  ph_not_full = 4'h0;
  logic [3:0]  ctrl = 4'h0;
  logic [3:0]  hp_select;
  logic [3:0]  ph_select;
  logic        p_irq_b;
  logic        p_nmi_b;

  tube_p_regif_if bus ();

  tube_p_regif #(
    .NMI_MIN_LOW (3)
  ) dut (
    .p_phi2       (clk),
    .p_rst        (rst),
    .bus          (bus),
    .hp_data      (hp_data),
    .hp_avail     (hp_avail),
    .ph_not_full  (ph_not_full),
    .ctrl_q_i_j_m (ctrl),
    .hp_select    (hp_select),
    .ph_select    (ph_select),
    .p_irq_b      (p_irq_b),
    .p_nmi_b      (p_nmi_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         sig;
    logic [7:0] exp;
    string      nm;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] mon_act;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] sample(input int sig);
    case (sig)
      SIG_HP:   return {4'h0, hp_select};
      SIG_PH:   return {4'h0, ph_select};
      SIG_DOUT: return bus.p_dout;
      SIG_IRQ:  return {7'h0, p_irq_b};
      default:  return {7'h0, p_nmi_b};
    endcase
  endfunction

  task automatic chk(input int dc, input int sig,
                     input logic [7:0] v, input string nm);
    exp_t e;
    e.cyc = cyc + dc;
    e.sig = sig;
    e.exp = v;
    e.nm  = nm;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: check every expectation due in this cycle
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        n_chk++;
        mon_act = sample(q[i].sig);
        if (q[i].cyc < cyc || mon_act !== q[i].exp) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got=%h want=%h",
                   q[i].nm, q[i].cyc, mon_act, q[i].exp);
        end
        q.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=running want=done", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bus.p_cs_b = 1'b0;
    bus.p_addr = 3'b011;
    bus.p_rdnw = 1'b1;

    // reset with an access held low throughout
    tick();
    chk(0, SIG_HP, 8'h00, "rst_hp");
    chk(0, SIG_DOUT, 8'h00, "rst_dout");
    chk(0, SIG_IRQ, 8'h01, "rst_irq");
    chk(0, SIG_NMI, 8'h01, "rst_nmi");
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk(k, SIG_HP, 8'h00, "post_rst_hp");
      chk(k, SIG_PH, 8'h00, "post_rst_ph");
      chk(k, SIG_DOUT, 8'h00, "post_rst_dout");
      chk(k, SIG_IRQ, 8'h01, "post_rst_irq");
      chk(k, SIG_NMI, 8'h01, "post_rst_nmi");
    end
    repeat (3) tick();
    bus.p_cs_b = 1'b1;
    tick();

    // data read R2 held 4 cycles
    bus.p_cs_b = 1'b0;
    bus.p_addr = 3'b011;
    bus.p_rdnw = 1'b1;
    chk(0, SIG_HP, 8'h02, "rd_r2_sel");
    chk(0, SIG_PH, 8'h00, "rd_r2_ph");
    chk(1, SIG_DOUT, 8'hA5, "rd_r2_dout");
    tick();
    hp_data = 32'hFFFFFFFF;
    for (int k = 0; k < 3; k++) begin
      chk(k, SIG_HP, 8'h00, "rd_r2_once");
      chk(k + 1, SIG_DOUT, 8'hA5, "rd_r2_hold");
    end
    repeat (3) tick();
    bus.p_cs_b = 1'b1;
    tick();

    // status read R4, J set so PIRQ follows R4 avail
    hp_avail = 4'b1000;
    ph_not_full = 4'b0111;
    ctrl = 4'b1010;
    bus.p_cs_b = 1'b0;
    bus.p_addr = 3'b110;
    bus.p_rdnw = 1'b1;
    chk(0, SIG_HP, 8'h00, "st_r4_nostrobe");
    chk(1, SIG_DOUT, 8'hAB, "st_r4_dout");
    chk(1, SIG_IRQ, 8'h00, "irq_j_r4");
    tick();
    bus.p_cs_b = 1'b1;
    hp_avail = 4'h0;
    ph_not_full = 4'h0;
    ctrl = 4'h0;
    chk(1, SIG_IRQ, 8'h01, "irq_j_clr");
    chk(1, SIG_DOUT, 8'hAB, "st_r4_hold");
    tick();

    // data write R1
    bus.p_cs_b = 1'b0;
    bus.p_addr = 3'b001;
    bus.p_rdnw = 1'b0;
    chk(0, SIG_PH, 8'h01, "wr_r1_sel");
    chk(0, SIG_HP, 8'h00, "wr_r1_hp");
    tick();
    chk(0, SIG_PH, 8'h00, "wr_r1_once");
    chk(0, SIG_DOUT, 8'hAB, "wr_r1_dout");
    tick();
    bus.p_cs_b = 1'b1;
    tick();

    // status write is ignored
    bus.p_cs_b = 1'b0;
    bus.p_addr = 3'b000;
    bus.p_rdnw = 1'b0;
    chk(0, SIG_PH, 8'h00, "stw_ph");
    chk(0, SIG_HP, 8'h00, "stw_hp");
    chk(1, SIG_DOUT, 8'hAB, "stw_dout");
    tick();
    bus.p_cs_b = 1'b1;
    tick();

    // data read R4, top byte lane
    hp_data = 32'hC3000000;
    bus.p_cs_b = 1'b0;
    bus.p_addr = 3'b111;
    bus.p_rdnw = 1'b1;
    chk(0, SIG_HP, 8'h08, "rd_r4_sel");
    chk(1, SIG_DOUT, 8'hC3, "rd_r4_dout");
    tick();
    bus.p_cs_b = 1'b1;
    chk(1, SIG_DOUT, 8'hC3, "rd_r4_hold");
    tick();

    // status read R1 with I set
    hp_avail = 4'b0001;
    ph_not_full = 4'b0001;
    ctrl = 4'b0101;
    bus.p_cs_b = 1'b0;
    bus.p_addr = 3'b000;
    bus.p_rdnw = 1'b1;
    chk(1, SIG_DOUT, 8'hD7, "st_r1_dout");
    chk(1, SIG_IRQ, 8'h00, "irq_st_r1");
    tick();
    bus.p_cs_b = 1'b1;
    ctrl = 4'h0;
    hp_avail = 4'h0;
    ph_not_full = 4'h0;
    chk(1, SIG_IRQ, 8'h01, "irq_st_r1_clr");
    tick();

    // PIRQ from I and R1 avail, then clear I
    ctrl = 4'b0100;
    hp_avail = 4'b0001;
    chk(0, SIG_IRQ, 8'h01, "irq_pre");
    chk(1, SIG_IRQ, 8'h00, "irq_i_set");
    tick();
    tick();
    ctrl = 4'h0;
    chk(0, SIG_IRQ, 8'h00, "irq_i_held");
    chk(1, SIG_IRQ, 8'h01, "irq_i_clr");
    tick();
    ctrl = 4'b0100;
    hp_avail = 4'b1000;
    chk(1, SIG_IRQ, 8'h01, "irq_i_r4_mask");
    tick();
    ctrl = 4'h0;
    hp_avail = 4'h0;
    tick();

    // PNMI: 1-cycle request gives minimum pulse
    ctrl = 4'b0001;
    hp_avail = 4'b0100;
    chk(0, SIG_NMI, 8'h01, "nmi_pre");
    for (int k = 1; k <= 3; k++)
      chk(k, SIG_NMI, 8'h00, "nmi_min_low");
    chk(4, SIG_NMI, 8'h01, "nmi_min_end");
    tick();
    hp_avail = 4'h0;
    repeat (5) tick();

    // PNMI: 10-cycle request
    hp_avail = 4'b0100;
    chk(0, SIG_NMI, 8'h01, "nmi_long_pre");
    for (int k = 1; k <= 10; k++)
      chk(k, SIG_NMI, 8'h00, "nmi_long_low");
    chk(11, SIG_NMI, 8'h01, "nmi_long_end");
    repeat (10) tick();
    hp_avail = 4'h0;
    repeat (3) tick();

    // PNMI: request re-rises right after HOLD exit
    hp_avail = 4'b0100;
    chk(0, SIG_NMI, 8'h01, "nmi_rr_pre");
    for (int k = 1; k <= 4; k++)
      chk(k, SIG_NMI, 8'h00, "nmi_rr_low1");
    chk(5, SIG_NMI, 8'h01, "nmi_rr_gap");
    for (int k = 6; k <= 8; k++)
      chk(k, SIG_NMI, 8'h00, "nmi_rr_low2");
    chk(9, SIG_NMI, 8'h01, "nmi_rr_end");
    repeat (4) tick();
    hp_avail = 4'h0;
    tick();
    hp_avail = 4'b0100;
    tick();
    hp_avail = 4'h0;
    repeat (5) tick();
    ctrl = 4'h0;

    // reset during an access start, then re-arm
    bus.p_cs_b = 1'b0;
    bus.p_addr = 3'b011;
    bus.p_rdnw = 1'b1;
    rst = 1'b1;
    chk(0, SIG_HP, 8'h00, "rst_mid_sel");
    chk(1, SIG_DOUT, 8'h00, "rst_mid_dout");
    tick();
    rst = 1'b0;
    hp_data = 32'h00005A00;
    chk(0, SIG_HP, 8'h00, "rst_mid_post");
    tick();
    chk(0, SIG_HP, 8'h00, "rst_mid_post2");
    tick();
    bus.p_cs_b = 1'b1;
    tick();
    bus.p_cs_b = 1'b0;
    chk(0, SIG_HP, 8'h02, "rearm_sel");
    chk(1, SIG_DOUT, 8'h5A, "rearm_dout");
    tick();
    bus.p_cs_b = 1'b1;
    repeat (3) tick();

    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL queue_drain got=%0d want=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tube_p_regif.md
# tube_p_regif

Parasite-side register interface of the Tube. It decodes parasite CPU accesses to the eight parasite-side Tube addresses and generates one-cycle data-select strobes for the four host-to-parasite byte buffers and the four parasite-to-host buffers. It returns registered read data (status or data byte) and produces the parasite interrupt outputs PIRQ and PNMI from buffer flags and host-written control bits. It sits directly downstream of the host-to-parasite byte buffers, consuming their data and data-available flags, and upstream of the parasite CPU bus.

## Interface
- NMI_MIN_LOW, 2: minimum number of cycles p_nmi_b stays low once asserted (1..15).
- p_phi2  in  1  parasite clock; all state on rising edge
- p_rst  in  1  synchronous, active-high reset
- p_cs_b  in  1  Tube chip select, active low
- p_addr  in  3  register address; [2:1] = channel 0..3 (R1..R4), [0] = 0 status / 1 data
- p_rdnw  in  1  1 = read, 0 = write
- hp_data  in  4x8  data bytes from the host-to-parasite buffers, channel-packed [31:0]
- hp_avail  in  4  per-channel data available, from the host-to-parasite buffers
- ph_not_full  in  4  per-channel parasite-to-host buffer can accept a byte
- ctrl_q_i_j_m  in  4  host control flags {Q,I,J,M}, already synchronised into p_phi2
- hp_select  out  4  one-cycle read strobe to host-to-parasite buffer n (its p_selectData)
- ph_select  out  4  one-cycle write strobe to parasite-to-host buffer n
- p_dout  out  8  registered read data
- p_irq_b  out  1  parasite IRQ, active low
- p_nmi_b  out  1  parasite NMI, active low

## Operation
- Access start: `start = !p_cs_b & cs_b_q`, where cs_b_q is p_cs_b registered (reset value 1). Strobes and read capture occur only on start. An access held for N cycles produces exactly one strobe.
- Data read (p_addr[0]=1, p_rdnw=1) on start:
  - hp_select[ch] is high for that cycle only.
  - p_dout <= hp_data[ch*8 +: 8].
- Data write (p_addr[0]=1, p_rdnw=0) on start:
  - ph_select[ch] is high for that cycle only.
  - p_dout is unchanged.
- Status read (p_addr[0]=0, p_rdnw=1) on start:
  - p_dout <= {hp_avail[ch], ph_not_full[ch], ctrl bits, 2'b11}.
  - The 4 ctrl bits are placed in bits [5:2] of the status byte.
  - No strobe is issued.
- Status write: ignored. No strobe, no state change.
- p_dout holds its last value between accesses.
- PIRQ: p_irq_b <= !((I & hp_avail[0]) | (J & hp_avail[3])), registered.
- PNMI:
  - nmi_req = M & hp_avail[2].
  - FSM states IDLE, ASSERT, HOLD. p_nmi_b = 0 in ASSERT and HOLD.
  - IDLE -> ASSERT on nmi_req; the counter loads NMI_MIN_LOW-1.
  - ASSERT counts down. At 0: go to HOLD if nmi_req, otherwise IDLE.
  - HOLD -> IDLE when nmi_req falls.
  - Counter width is 4 bits.
- Reset values: p_dout = 8'h00, p_irq_b = 1, p_nmi_b = 1, hp_select = ph_select = 0, FSM = IDLE, cs_b_q = 1.
- Reset mid-access: the strobe is suppressed in the reset cycle. After reset releases with p_cs_b still low, no strobe is issued until p_cs_b has gone high and then low again.

## Timing
- Strobes are combinational from start and cs_b_q. They are valid in the same cycle p_cs_b is first sampled low.
- p_dout and the interrupt outputs have 1-cycle latency.
- A buffer clears its flag on the same edge as the strobe. Status reads therefore see the cleared flag one cycle later.
- Back-to-back accesses need p_cs_b high for at least 1 cycle between them.
- Simultaneous events:
  - nmi_req falling while in ASSERT does not shorten the pulse.
  - nmi_req re-rising in the cycle after HOLD -> IDLE starts a new assertion.

## Structure
- Shared package tube_pkg holds:
  - channel index constants R1..R4 = 0..3
  - status bit positions (AVAIL=7, NOT_FULL=6)
  - control flag positions {Q,I,J,M}
- One sub-module: tube_nmi_gen, containing the PNMI FSM and hold counter.
- Decode, strobes, read mux and PIRQ stay in the top level.

## Test plan
- Reset with p_cs_b low for 3 cycles after release -> no strobes; p_dout = 00, p_irq_b = p_nmi_b = 1.
- Data read of R2 (p_addr = 3'b011), p_cs_b low for 4 cycles, hp_data[15:8] = 8'hA5 -> hp_select = 4'b0010 for exactly 1 cycle; p_dout = A5 the next cycle and held.
- Status read of R4 with hp_avail[3] = 1, ph_not_full[3] = 0, ctrl = 4'b1010 -> p_dout = 8'b1010_1011.
- Data write to R1 -> ph_select = 4'b0001 for 1 cycle; hp_select stays 0; p_dout unchanged.
- I = 1 and hp_avail[0] rising -> p_irq_b low 1 cycle later. Clearing I -> high 1 cycle later.
- M = 1, hp_avail[2] high for 1 cycle, NMI_MIN_LOW = 3 -> p_nmi_b low for exactly 3 cycles. Held high for 10 cycles -> p_nmi_b low until 1 cycle after the fall.
